// File: rtl/rom_stream.sv
// rom_stream: streams a burst of words from a ROM image over a valid/ready
// interface. Each burst has its own start address, length and loop mode.
// The address wraps at the end of the ROM, and a burst can be aborted with stop.
module rom_stream #(
  parameter int    W    = 8,
  parameter int    SIZE = 256,
  parameter string FILE = "",
  localparam int   AW   = $clog2(SIZE),
  localparam int   LW   = $clog2(SIZE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] count,
  input  logic          loop,
  input  logic          stop,
  output logic [W-1:0]  data,
  output logic          valid,
  input  logic          ready,
  output logic          last,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  rom [SIZE];
  logic [W-1:0]  rom_q;
  logic          data_clr;

  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] remaining;
  logic [LW-1:0] cfg_count;
  logic [LW-1:0] count_clamped;
  logic          cfg_loop;

  logic          take;
  logic          fetch;
  logic          pass_end;
  logic          accept;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: stop overrides everything; a non-looping pass ends in IDLE.
  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (take) state_nx = RUN;
        RUN:     if (pass_end && !cfg_loop) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Control strobes and status outputs.
  always_comb begin
    busy          = (state == RUN) || valid;
    take          = (state == IDLE) && !valid && start && !stop && (count != '0);
    fetch         = (state == RUN) && (remaining != '0) && (!valid || ready) && !stop;
    pass_end      = fetch && (remaining == LW'(1));
    accept        = valid && ready;
    count_clamped = (count > LW'(SIZE)) ? LW'(SIZE) : count;
    addr_inc      = (addr == AW'(SIZE - 1)) ? '0 : addr + 1'b1;
    data          = data_clr ? '0 : rom_q;
  end

  // Synchronous ROM read port; left without reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (fetch) begin
      rom_q <= rom[addr];
    end
  end

  // Burst datapath: address/length tracking and the valid/last handshake.
  // The async-reset data_clr flag forces data to zero until the first fetch,
  // which gives a reset value on data without putting a reset on the RAM output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid     <= 1'b0;
      last      <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      cfg_base  <= '0;
      cfg_count <= '0;
      cfg_loop  <= 1'b0;
      data_clr  <= 1'b1;
    end else if (stop) begin
      valid     <= 1'b0;
      last      <= 1'b0;
      remaining <= '0;
    end else if (take) begin
      addr      <= base;
      remaining <= count_clamped;
      cfg_base  <= base;
      cfg_count <= count_clamped;
      cfg_loop  <= loop;
    end else if (fetch) begin
      valid    <= 1'b1;
      last     <= pass_end;
      data_clr <= 1'b0;
      if (pass_end && cfg_loop) begin
        addr      <= cfg_base;
        remaining <= cfg_count;
      end else begin
        addr      <= addr_inc;
        remaining <= remaining - 1'b1;
      end
    end else if (accept) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_stream.sv
// Directed bench for rom_stream with SIZE=16 and ROM contents m[i] = 8'h10 + i.
module tb_rom_stream;

  localparam int W    = 8;
  localparam int SIZE = 16;
  localparam int AW   = 4;
  localparam int LW   = 5;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] count;
  logic          loop;
  logic          stop;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic          last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  rom_stream #(.W(W), .SIZE(SIZE)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .base  (base),
    .count (count),
    .loop  (loop),
    .stop  (stop),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .last  (last),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "/valid"}, 32'(valid), 32'd1);
    chk({tag, "/data"},  32'(data),  32'(d));
    chk({tag, "/last"},  32'(last),  32'(l));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "/valid"}, 32'(valid), 32'd0);
    chk({tag, "/last"},  32'(last),  32'd0);
    chk({tag, "/busy"},  32'(busy),  32'd0);
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [LW-1:0] c, input logic lp);
    start = 1'b1;
    base  = b;
    count = c;
    loop  = lp;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    base  = '0;
    count = '0;
    loop  = 1'b0;
    stop  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < SIZE; i++) dut.rom[i] = 8'h10 + 8'(i);

    // Reset state, before any clock edge.
    #2;
    chk("rst/data", 32'(data), 32'd0);
    expect_idle("rst");
    reset = 1'b1;

    // 1: base=3 count=4 with ready held high.
    go(4'd3, 5'd4, 1'b0);
    chk("t1/lat_valid", 32'(valid), 32'd0);
    chk("t1/lat_busy",  32'(busy),  32'd1);
    tick(); expect_word("t1/w0", 8'h13, 1'b0);
    tick(); expect_word("t1/w1", 8'h14, 1'b0);
    tick(); expect_word("t1/w2", 8'h15, 1'b0);
    tick(); expect_word("t1/w3", 8'h16, 1'b1);
    chk("t1/busy_last", 32'(busy), 32'd1);
    tick(); expect_idle("t1/end");

    // 2: wrap at the end of the ROM; started in the cycle busy fell.
    go(4'd14, 5'd4, 1'b0);
    tick(); expect_word("t2/w0", 8'h1E, 1'b0);
    tick(); expect_word("t2/w1", 8'h1F, 1'b0);
    tick(); expect_word("t2/w2", 8'h10, 1'b0);
    tick(); expect_word("t2/w3", 8'h11, 1'b1);
    tick(); expect_idle("t2/end");

    // 3: backpressure, ready pattern 1,0,0 repeating.
    go(4'd3, 5'd4, 1'b0);
    ready = 1'b1; tick(); expect_word("t3/a", 8'h13, 1'b0);
    ready = 1'b0; tick(); expect_word("t3/b", 8'h13, 1'b0);
    ready = 1'b0; tick(); expect_word("t3/c", 8'h13, 1'b0);
    ready = 1'b1; tick(); expect_word("t3/d", 8'h14, 1'b0);
    ready = 1'b0; tick(); expect_word("t3/e", 8'h14, 1'b0);
    ready = 1'b0; tick(); expect_word("t3/f", 8'h14, 1'b0);
    ready = 1'b1; tick(); expect_word("t3/g", 8'h15, 1'b0);
    ready = 1'b0; tick(); expect_word("t3/h", 8'h15, 1'b0);
    ready = 1'b0; tick(); expect_word("t3/i", 8'h15, 1'b0);
    ready = 1'b1; tick(); expect_word("t3/j", 8'h16, 1'b1);
    ready = 1'b0; tick(); expect_word("t3/k", 8'h16, 1'b1);
    chk("t3/k_busy", 32'(busy), 32'd1);
    ready = 1'b0; tick(); expect_word("t3/l", 8'h16, 1'b1);
    ready = 1'b1; tick(); expect_idle("t3/end");

    // 4: loop mode without bubbles, then stop mid-pass.
    go(4'd2, 5'd3, 1'b1);
    loop = 1'b0;
    tick(); expect_word("t4/p0w0", 8'h12, 1'b0);
    tick(); expect_word("t4/p0w1", 8'h13, 1'b0);
    tick(); expect_word("t4/p0w2", 8'h14, 1'b1);
    tick(); expect_word("t4/p1w0", 8'h12, 1'b0);
    tick(); expect_word("t4/p1w1", 8'h13, 1'b0);
    tick(); expect_word("t4/p1w2", 8'h14, 1'b1);
    tick(); expect_word("t4/p2w0", 8'h12, 1'b0);
    stop = 1'b1;
    tick(); expect_idle("t4/stop");
    stop = 1'b0;
    tick(); expect_idle("t4/after");

    // 5a: start held while busy with different parameters is ignored.
    go(4'd0, 5'd4, 1'b0);
    start = 1'b1;
    base  = 4'd8;
    count = 5'd2;
    tick(); expect_word("t5/w0", 8'h10, 1'b0);
    tick(); expect_word("t5/w1", 8'h11, 1'b0);
    tick(); expect_word("t5/w2", 8'h12, 1'b0);
    tick(); expect_word("t5/w3", 8'h13, 1'b1);
    tick(); expect_idle("t5/end");
    start = 1'b0;
    tick(); expect_idle("t5/no_restart");

    // 5b: start with count=0 is ignored.
    go(4'd5, 5'd0, 1'b0);
    expect_idle("t5/cnt0_a");
    tick(); expect_idle("t5/cnt0_b");

    // 5c: start together with stop is ignored.
    stop = 1'b1;
    go(4'd5, 5'd3, 1'b0);
    stop = 1'b0;
    expect_idle("t5/ststop_a");
    tick(); expect_idle("t5/ststop_b");

    // Single-word burst at the last ROM address.
    go(4'd15, 5'd1, 1'b0);
    tick(); expect_word("one/w0", 8'h1F, 1'b1);
    tick(); expect_idle("one/end");

    // Oversized count is clamped to SIZE: one full pass from address 5.
    go(4'd5, 5'd31, 1'b0);
    for (int i = 0; i < SIZE; i++) begin
      tick();
      expect_word($sformatf("clamp/w%0d", i), 8'h10 + 8'((5 + i) % SIZE), (i == SIZE - 1));
    end
    tick(); expect_idle("clamp/end");

    // 6: asynchronous reset in the middle of a burst.
    go(4'd3, 5'd4, 1'b0);
    tick(); expect_word("t6/w0", 8'h13, 1'b0);
    tick(); expect_word("t6/w1", 8'h14, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6/rst_data", 32'(data), 32'd0);
    expect_idle("t6/rst");
    #2 reset = 1'b1;
    tick(); expect_idle("t6/post");
    go(4'd0, 5'd2, 1'b0);
    tick(); expect_word("t6/w0b", 8'h10, 1'b0);
    tick(); expect_word("t6/w1b", 8'h11, 1'b1);
    tick(); expect_idle("t6/end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
